// File: rtl/gullfaxi_sink.sv
// Receiving end of the Gullfaxi output-port protocol: round-robin grant of whole
// packets that fit in the local FWFT buffer, re-emitted as a valid/ready byte stream.
//
// state  | meaning
// S_IDLE | arbitrate; grant the next eligible port whose packet fits
// S_WAIT | grant issued, waiting for start from the granted port
// S_RECV | capturing one word per cycle until end or length reached
module gullfaxi_sink #(
   parameter int NPORTS   = 3,
   parameter int DEPTH    = 64,
   parameter int LOGDEPTH = 6,
   parameter int TIMEOUT  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NPORTS-1:0]     R_req,
   input  logic [6*NPORTS-1:0]   R_length,
   input  logic [NPORTS-1:0]     R_start,
   input  logic [8*NPORTS-1:0]   R_data,
   input  logic [NPORTS-1:0]     R_end,
   output logic [NPORTS-1:0]     R_grant,
   output logic                  O_valid,
   output logic [7:0]            O_data,
   output logic                  O_end,
   input  logic                  O_ready,
   output logic                  err_timeout,
   output logic                  err_length
);

   localparam int LW = 6;
   localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [LOGDEPTH:0] DEPTH_W = (LOGDEPTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RECV
   } state_t;

   state_t            state;
   logic [PW-1:0]     port;
   logic [PW-1:0]     last;
   logic [LW-1:0]     len;
   logic [LW-1:0]     cnt;
   logic [TW-1:0]     to_cnt;

   logic [8:0]            mem [DEPTH];
   logic [LOGDEPTH-1:0]   wr_ptr;
   logic [LOGDEPTH-1:0]   rd_ptr;
   logic [LOGDEPTH:0]     n_elems;
   logic [LOGDEPTH:0]     free;
   logic [8:0]            head;

   logic [LW-1:0]     req_len [NPORTS];
   logic [NPORTS-1:0] elig;
   logic              pick_found;
   logic [PW-1:0]     pick_port;
   logic [LW-1:0]     pick_len;
   logic [NPORTS-1:0] pick_onehot;

   logic              cur_start;
   logic              cur_end;
   logic [7:0]        cur_data;
   logic              at_len;
   logic              word_end;
   logic              len_err;
   logic              push;
   logic              pop;

   assign free = DEPTH_W - n_elems;

   always_comb begin
      req_len = '{default: '0};
      elig    = '0;
      for (int i = 0; i < NPORTS; i++) begin
         req_len[i] = R_length[LW*i +: LW];
         elig[i]    = R_req[i] && (req_len[i] != '0) &&
                      ((LOGDEPTH+1)'(req_len[i]) <= free);
      end
   end

   // Round-robin: ports above last first, then wrap around to those at or below it.
   always_comb begin
      pick_found  = 1'b0;
      pick_port   = '0;
      pick_len    = '0;
      pick_onehot = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (!pick_found && elig[i] && (PW'(i) > last)) begin
            pick_found = 1'b1;
            pick_port  = PW'(i);
            pick_len   = req_len[i];
         end
      end
      for (int i = 0; i < NPORTS; i++) begin
         if (!pick_found && elig[i] && (PW'(i) <= last)) begin
            pick_found = 1'b1;
            pick_port  = PW'(i);
            pick_len   = req_len[i];
         end
      end
      for (int i = 0; i < NPORTS; i++) begin
         pick_onehot[i] = pick_found && (PW'(i) == pick_port);
      end
   end

   always_comb begin
      cur_start = 1'b0;
      cur_end   = 1'b0;
      cur_data  = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (PW'(i) == port) begin
            cur_start = R_start[i];
            cur_end   = R_end[i];
            cur_data  = R_data[8*i +: 8];
         end
      end
   end

   // cnt is 0 in WAIT, so one compare covers both word 0 and later words.
   assign at_len   = (cnt == (len - LW'(1)));
   assign word_end = cur_end || at_len;
   assign len_err  = cur_end ^ at_len;
   assign push     = ((state == S_WAIT) && cur_start) || (state == S_RECV);
   assign pop      = O_valid && O_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         port        <= '0;
         last        <= PW'(NPORTS - 1);
         len         <= '0;
         cnt         <= '0;
         to_cnt      <= '0;
         R_grant     <= '0;
         err_timeout <= 1'b0;
         err_length  <= 1'b0;
      end else begin
         R_grant     <= '0;
         err_timeout <= 1'b0;
         err_length  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  R_grant <= pick_onehot;
                  port    <= pick_port;
                  len     <= pick_len;
                  last    <= pick_port;
                  cnt     <= '0;
                  to_cnt  <= '0;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cur_start) begin
                  cnt <= LW'(1);
                  if (word_end) begin
                     err_length <= len_err;
                     state      <= S_IDLE;
                  end else begin
                     state <= S_RECV;
                  end
               end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            S_RECV: begin
               cnt <= cnt + LW'(1);
               if (word_end) begin
                  err_length <= len_err;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {word_end, cur_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         n_elems <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   n_elems <= n_elems + 1'b1;
            2'b01:   n_elems <= n_elems - 1'b1;
            default: n_elems <= n_elems;
         endcase
      end
   end

   assign head    = mem[rd_ptr];
   assign O_valid = (n_elems != '0);
   assign O_data  = O_valid ? head[7:0] : 8'h00;
   assign O_end   = O_valid && head[8];

endmodule
